// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder and its downstream c collector:
// FSM state encoding and MSB-first lane packing helpers.
package systolic_skew_feeder_pkg;

    typedef logic [1:0] feeder_state_t;

    localparam feeder_state_t ST_IDLE   = 2'd0;
    localparam feeder_state_t ST_STREAM = 2'd1;
    localparam feeder_state_t ST_DRAIN  = 2'd2;

    // Lane 0 occupies the most significant slice of a packed vector.
    function automatic int unsigned lane_msb(input int unsigned lane,
                                             input int unsigned lanes,
                                             input int unsigned width);
        return width * (lanes - lane) - 1;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned lanes,
                                             input int unsigned width);
        return width * (lanes - lane - 1);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register chain for one lane: output is the input delayed by
// 'delay' clock cycles, cleared asynchronously.
module skew_delay_line #(
    parameter int unsigned data_size = 16,
    parameter int unsigned delay     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] d,
    output logic [data_size-1:0] q
);

    logic [data_size-1:0] stage [delay];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < delay; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned k = 1; k < delay; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[delay-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for continuous_systolic: skews A/B lanes diagonally, pulses the
// array's reset_counter at tile start, zero-flushes after the last beat, flags completion.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned data_size = 16,
    parameter int unsigned size      = 3,
    parameter int unsigned max_depth = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [data_size*size-1:0] a_in,
    input  logic [data_size*size-1:0] b_in,
    output logic [data_size*size-1:0] a,
    output logic [data_size*size-1:0] b,
    output logic                      reset_counter,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      overflow
);

    localparam int unsigned BW = (max_depth > 1) ? $clog2(max_depth) : 1;
    localparam int unsigned DW = $clog2(2 * size);
    localparam logic [BW-1:0] LAST_IDX   = BW'(max_depth - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * size - 1);

    feeder_state_t             state;
    logic [BW-1:0]             beat_cnt;
    logic [BW-1:0]             beat_nxt;
    logic [DW-1:0]             drain_cnt;
    logic                      accept;
    logic                      hit_max;
    logic                      close_tile;
    logic [data_size*size-1:0] a_line;
    logic [data_size*size-1:0] b_line;

    assign in_ready  = (state == ST_IDLE) || (state == ST_STREAM);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == ST_STREAM) || (state == ST_DRAIN);
    assign tile_done = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

    // beat_cnt holds the zero-based index of the most recently accepted beat.
    assign beat_nxt   = beat_cnt + BW'(1);
    assign hit_max    = (state == ST_IDLE) ? (LAST_IDX == '0) : (beat_nxt == LAST_IDX);
    assign close_tile = accept && (in_last || hit_max);

    assign a_line = accept ? a_in : '0;
    assign b_line = accept ? b_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            drain_cnt     <= '0;
            reset_counter <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the first beat's lane 0 on a.
            reset_counter <= accept && (state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        if (close_tile) begin
                            state <= ST_DRAIN;
                            if (!in_last) overflow <= 1'b1;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_nxt;
                        if (close_tile) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                            if (!in_last) overflow <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= ST_IDLE;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < size; i++) begin : g_lane
        localparam int unsigned MSB = lane_msb(i, size, data_size);

        skew_delay_line #(
            .data_size(data_size),
            .delay    (i + 1)
        ) u_skew_a (
            .clk  (clk),
            .reset(reset),
            .d    (a_line[MSB -: data_size]),
            .q    (a[MSB -: data_size])
        );

        skew_delay_line #(
            .data_size(data_size),
            .delay    (i + 1)
        ) u_skew_b (
            .clk  (clk),
            .reset(reset),
            .d    (b_line[MSB -: data_size]),
            .q    (b[MSB -: data_size])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle scoreboard of skewed lanes
// plus rule-derived expectations for handshake, tile pulses and overflow.
module tb_systolic_skew_feeder;

    localparam int DS = 16;
    localparam int SZ = 3;
    localparam int MD = 4;
    localparam int W  = DS * SZ;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         reset_counter;
    logic         busy;
    logic         tile_done;
    logic         overflow;

    systolic_skew_feeder #(
        .data_size(DS),
        .size     (SZ),
        .max_depth(MD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .a_in         (a_in),
        .b_in         (b_in),
        .a            (a),
        .b            (b),
        .reset_counter(reset_counter),
        .busy         (busy),
        .tile_done    (tile_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ha[$];
    logic [W-1:0] hb[$];
    int vectors     = 0;
    int miscompares = 0;
    int n;
    int start_cyc;
    int last_cyc;
    int ovf_from;
    int beats;
    bit closed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic init_model();
        ha.delete();
        hb.delete();
        for (int i = 0; i < SZ; i++) begin
            ha.push_back('0);
            hb.push_back('0);
        end
        n         = 0;
        start_cyc = -100;
        last_cyc  = -100;
        ovf_from  = 1 << 30;
        beats     = 0;
        closed    = 1'b1;
    endtask

    // Lane i shows what was pushed i+1 cycles ago (queue tail is the previous cycle).
    function automatic logic [W-1:0] skewed(input logic [W-1:0] h [$]);
        logic [W-1:0] e;
        logic [W-1:0] src;
        e = '0;
        for (int i = 0; i < SZ; i++) begin
            src = h[SZ-1-i];
            e[DS*(SZ-i)-1 -: DS] = src[DS*(SZ-i)-1 -: DS];
        end
        return e;
    endfunction

    task automatic step(input bit v, input bit l, input logic [W-1:0] ai, input logic [W-1:0] bi);
        bit er;
        bit acc;
        in_valid = v;
        in_last  = l;
        a_in     = ai;
        b_in     = bi;
        #1;
        er = !(n > last_cyc && n <= last_cyc + 2*SZ);
        chk("a",             64'(a),             64'(skewed(ha)));
        chk("b",             64'(b),             64'(skewed(hb)));
        chk("in_ready",      64'(in_ready),      64'(er));
        chk("reset_counter", 64'(reset_counter), 64'(n == start_cyc + 1));
        chk("tile_done",     64'(tile_done),     64'(n == last_cyc + 2*SZ));
        chk("busy",          64'(busy),          64'(n > start_cyc && (!closed || n <= last_cyc + 2*SZ)));
        chk("overflow",      64'(overflow),      64'(n >= ovf_from));
        acc = v && er;
        if (acc) begin
            if (closed) begin
                start_cyc = n;
                closed    = 1'b0;
                beats     = 0;
            end
            beats++;
            if (l || beats == MD) begin
                closed   = 1'b1;
                last_cyc = n;
                if (!l && ovf_from > n) ovf_from = n + 1;
            end
        end
        ha.push_back(acc ? ai : '0);
        hb.push_back(acc ? bi : '0);
        void'(ha.pop_front());
        void'(hb.pop_front());
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, '0, '0);
    endtask

    localparam logic [W-1:0] ONE3   = {16'h0100, 16'h0100, 16'h0100};
    localparam logic [W-1:0] TWO3   = {16'h0200, 16'h0200, 16'h0200};
    localparam logic [W-1:0] THREE3 = {16'h0300, 16'h0300, 16'h0300};
    localparam logic [W-1:0] RAMP   = {16'h0100, 16'h0200, 16'h0300};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        init_model();

        // Reset state, then a single beat with in_last
        idle(2);
        step(1'b1, 1'b1, RAMP, ONE3);
        idle(8);

        // Three-beat tile, 1.0/2.0/3.0 against 1.0
        step(1'b1, 1'b0, ONE3, ONE3);
        step(1'b1, 1'b0, TWO3, ONE3);
        step(1'b1, 1'b1, THREE3, ONE3);
        idle(8);

        // Same tile with two stall cycles between beats 1 and 2
        step(1'b1, 1'b0, ONE3, ONE3);
        step(1'b0, 1'b1, 48'hdead_beef_cafe, 48'h1234_5678_9abc);
        step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, TWO3, ONE3);
        step(1'b1, 1'b1, THREE3, ONE3);
        idle(8);

        // in_valid held through DRAIN: nothing consumed until after tile_done
        step(1'b1, 1'b1, RAMP, TWO3);
        for (int k = 0; k < 2*SZ; k++) step(1'b1, 1'b1, 48'h0aaa_0bbb_0ccc, 48'h0ddd_0eee_0fff);
        step(1'b1, 1'b0, TWO3, THREE3);
        step(1'b1, 1'b1, ONE3, RAMP);
        idle(8);

        // Six beats without in_last: beat MD closes the tile and sets overflow
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, {16'(k+1), 16'(k+17), 16'(k+33)}, ONE3);
        idle(8);

        // Reset mid-STREAM: outputs clear immediately, no tile_done, overflow cleared
        step(1'b1, 1'b0, THREE3, TWO3);
        step(1'b1, 1'b0, TWO3, THREE3);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_a",         64'(a),         64'd0);
        chk("rst_b",         64'(b),         64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_model();
        idle(3);
        step(1'b1, 1'b1, RAMP, RAMP);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
